// File: rtl/led_panel_receiver.sv
// LED panel receiver: synchronises the panel driver's serial bus, shifts
// pixel data into per-colour row registers, latches completed rows, tracks
// the current row address and flags protocol errors.

// One colour lane: a COLS-bit shift chain plus the latched row copy.
module led_panel_lane #(
   parameter int COLS = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            shift_en,
   input  logic            latch_en,
   input  logic            bit_in,
   output logic [COLS-1:0] row_q
);

   logic [COLS-1:0] sr;
   logic [COLS-1:0] sr_nxt;

   // A latch in the same cycle as a shift must capture the freshly shifted bit.
   assign sr_nxt = shift_en ? {sr[COLS-2:0], bit_in} : sr;

   // Shift chain holds its contents across latches; only reset clears it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sr    <= '0;
         row_q <= '0;
      end else begin
         sr <= sr_nxt;
         if (latch_en) row_q <= sr_nxt;
      end
   end

endmodule

module led_panel_receiver #(
   parameter int COLS = 32,
   parameter int ROWS = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            red_in,
   input  logic            green_in,
   input  logic            blue_in,
   input  logic            sclk_in,
   input  logic            latch_in,
   input  logic            blank_in,
   input  logic            aclk_in,
   input  logic            arst_in,
   output logic [COLS-1:0] row_red,
   output logic [COLS-1:0] row_green,
   output logic [COLS-1:0] row_blue,
   output logic [3:0]      row_addr,
   output logic            row_valid,
   output logic            row_lit,
   output logic            frame_pulse,
   output logic            err_over,
   output logic            err_short
);

   localparam int CW = $clog2(COLS + 1);

   // Bus bit order: 0 red, 1 green, 2 blue, 3 sclk, 4 latch, 5 blank, 6 aclk, 7 arst
   logic [7:0] sync1;
   logic [7:0] sync2;
   logic [3:0] hist;       // delayed sclk, latch, aclk, arst
   logic [3:0] strobe_s;
   logic [3:0] rise;

   logic sclk_rise;
   logic latch_rise;
   logic aclk_rise;
   logic arst_rise;

   logic [CW-1:0]         cnt;
   logic [CW-1:0]         cnt_inc;
   logic [2:0][COLS-1:0]  lane_row;

   // Two-flop synchroniser for every panel input.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {arst_in, aclk_in, blank_in, latch_in, sclk_in, blue_in, green_in, red_in};
         sync2 <= sync1;
      end
   end

   assign strobe_s = {sync2[7], sync2[6], sync2[4], sync2[3]};

   // Edge history; clearing it to 0 makes a level held through reset count as a rise.
   always_ff @(posedge clk) begin
      if (!reset_n) hist <= '0;
      else          hist <= strobe_s;
   end

   assign rise       = strobe_s & ~hist;
   assign sclk_rise  = rise[0];
   assign latch_rise = rise[1];
   assign aclk_rise  = rise[2];
   assign arst_rise  = rise[3];

   // Counter after any same-cycle shift, saturating at COLS.
   assign cnt_inc = (sclk_rise && cnt != CW'(COLS)) ? cnt + 1'b1 : cnt;

   for (genvar l = 0; l < 3; l++) begin : g_lane
      led_panel_lane #(.COLS(COLS)) u_lane (
         .clk      (clk),
         .reset_n  (reset_n),
         .shift_en (sclk_rise),
         .latch_en (latch_rise),
         .bit_in   (sync2[l]),
         .row_q    (lane_row[l])
      );
   end

   assign row_red   = lane_row[0];
   assign row_green = lane_row[1];
   assign row_blue  = lane_row[2];

   // Shift counting, sticky error flags and latch handshake.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt       <= '0;
         err_over  <= 1'b0;
         err_short <= 1'b0;
         row_valid <= 1'b0;
      end else begin
         row_valid <= latch_rise;
         if (sclk_rise && cnt == CW'(COLS)) err_over <= 1'b1;
         if (latch_rise) begin
            cnt <= '0;
            if (cnt_inc != CW'(COLS)) err_short <= 1'b1;
         end else begin
            cnt <= cnt_inc;
         end
      end
   end

   // Row address, frame strobe and display enable; arst level beats aclk.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         row_addr    <= '0;
         frame_pulse <= 1'b0;
         row_lit     <= 1'b0;
      end else begin
         frame_pulse <= arst_rise;
         row_lit     <= ~sync2[5];
         if (sync2[7])
            row_addr <= '0;
         else if (aclk_rise)
            row_addr <= (row_addr == 4'(ROWS - 1)) ? 4'd0 : row_addr + 4'd1;
      end
   end

endmodule

// File: tb/tb_led_panel_receiver.sv
// Self-checking bench for led_panel_receiver: directed protocol cases with
// literal expectations plus randomised traffic against a behavioural model.
module tb_led_panel_receiver;

   localparam int COLS = 32;
   localparam int ROWS = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic red_in = 0, green_in = 0, blue_in = 0;
   logic sclk_in = 0, latch_in = 0, blank_in = 0, aclk_in = 0, arst_in = 0;
   logic [COLS-1:0] row_red, row_green, row_blue;
   logic [3:0]      row_addr;
   logic            row_valid, row_lit, frame_pulse, err_over, err_short;

   led_panel_receiver #(.COLS(COLS), .ROWS(ROWS)) dut (
      .clk(clk), .reset_n(reset_n),
      .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
      .sclk_in(sclk_in), .latch_in(latch_in), .blank_in(blank_in),
      .aclk_in(aclk_in), .arst_in(arst_in),
      .row_red(row_red), .row_green(row_green), .row_blue(row_blue),
      .row_addr(row_addr), .row_valid(row_valid), .row_lit(row_lit),
      .frame_pulse(frame_pulse), .err_over(err_over), .err_short(err_short)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int vld_cnt = 0;
   int frame_cnt = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // An input sample taken at edge k reaches the logic at edge k+2; it is
   // lost if reset was low at edge k or k+1. Rises compare consecutive samples.
   bit r0 = 1, r1 = 1, r2 = 1, r3 = 1;
   logic [7:0] i0 = 0, i1 = 0, i2 = 0, i3 = 0;
   bit qr[$], qg[$], qb[$];
   int shifts = 0;
   int e_addr = 0;
   logic [COLS-1:0] e_red = '0, e_green = '0, e_blue = '0;
   logic e_valid = 0, e_lit = 0, e_frame = 0, e_over = 0, e_short = 0;

   function automatic logic [COLS-1:0] qval(input bit q[$]);
      logic [COLS-1:0] v = '0;
      for (int i = 0; i < q.size(); i++) v[i] = q[q.size()-1-i];
      return v;
   endfunction

   task automatic model_step();
      logic [7:0] cur, prv, rs;
      r3 = r2; r2 = r1; r1 = r0; r0 = !reset_n;
      i3 = i2; i2 = i1; i1 = i0;
      i0 = {arst_in, aclk_in, blank_in, latch_in, sclk_in, blue_in, green_in, red_in};
      if (r0) begin
         qr.delete(); qg.delete(); qb.delete();
         shifts = 0; e_addr = 0;
         e_red = '0; e_green = '0; e_blue = '0;
         e_valid = 0; e_lit = 0; e_frame = 0; e_over = 0; e_short = 0;
         return;
      end
      cur = (r1 || r2) ? 8'h00 : i2;
      prv = (r2 || r3) ? 8'h00 : i3;
      rs  = cur & ~prv;
      e_valid = 0;
      if (rs[3]) begin
         qr.push_back(cur[0]); qg.push_back(cur[1]); qb.push_back(cur[2]);
         if (qr.size() > COLS) begin qr.pop_front(); qg.pop_front(); qb.pop_front(); end
         shifts++;
         if (shifts > COLS) e_over = 1;
      end
      if (rs[4]) begin
         if (shifts < COLS) e_short = 1;
         e_red = qval(qr); e_green = qval(qg); e_blue = qval(qb);
         e_valid = 1;
         shifts = 0;
      end
      if (cur[7]) e_addr = 0;
      else if (rs[6]) e_addr = (e_addr + 1) % ROWS;
      e_frame = rs[7];
      e_lit = !cur[5];
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Every-cycle comparison of all outputs against the model.
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         if (row_valid === 1'b1) vld_cnt++;
         if (frame_pulse === 1'b1) frame_cnt++;
         chk("cycle", 128'({row_red, row_green, row_blue, row_addr,
                            row_valid, row_lit, frame_pulse, err_over, err_short}),
                      128'({e_red, e_green, e_blue, 4'(e_addr),
                            e_valid, e_lit, e_frame, e_over, e_short}));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      reset_n = 0; step(3);
      reset_n = 1; step(3);
   endtask

   task automatic pix(input bit r, input bit g, input bit b);
      red_in = r; green_in = g; blue_in = b;
      sclk_in = 1; step(1);
      sclk_in = 0; step(1);
   endtask

   task automatic latch_p();
      latch_in = 1; step(1);
      latch_in = 0; step(3);
   endtask

   task automatic aclk_p();
      aclk_in = 1; step(1);
      aclk_in = 0; step(3);
   endtask

   int v0, f0;

   initial begin
      step(3);
      chk("reset_state", 128'({row_red, row_addr, row_valid, row_lit, frame_pulse, err_over, err_short}), 128'(0));
      reset_n = 1; step(3);

      // single red pixel first in a full row
      v0 = vld_cnt;
      for (int i = 0; i < COLS; i++) pix(i == 0, 0, 0);
      latch_p();
      chk("t1_row_red", 128'(row_red), 128'(32'h8000_0000));
      chk("t1_model_red", 128'(e_red), 128'(32'h8000_0000));
      chk("t1_errs", 128'({err_short, err_over}), 128'(0));
      chk("t1_valid_pulses", 128'(vld_cnt - v0), 128'(1));

      // short row, then sticky flag through three good rows, cleared by reset
      do_reset();
      v0 = vld_cnt;
      for (int i = 0; i < COLS - 1; i++) pix(1, 0, 1);
      latch_p();
      chk("t2_valid_pulses", 128'(vld_cnt - v0), 128'(1));
      chk("t2_err_short", 128'(err_short), 128'(1));
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < COLS; i++) pix(0, 1, 0);
         latch_p();
      end
      chk("t2_err_sticky", 128'({err_short, err_over}), 128'(2'b10));
      chk("t2_green", 128'(row_green), 128'(32'hFFFF_FFFF));
      reset_n = 0; step(2);
      chk("t2_err_cleared", 128'(err_short), 128'(0));
      reset_n = 1; step(3);

      // overlong row keeps the last COLS bits
      for (int i = 0; i < COLS + 1; i++) pix(i <= 1, 0, i == COLS);
      latch_p();
      chk("t3_err_over", 128'({err_over, err_short}), 128'(2'b10));
      chk("t3_row_red", 128'(row_red), 128'(32'h8000_0000));
      chk("t3_row_blue", 128'(row_blue), 128'(32'h0000_0001));

      // row address sequencing and frame pulse
      do_reset();
      f0 = frame_cnt;
      arst_in = 1; step(2); arst_in = 0; step(3);
      chk("t4_frame_once", 128'(frame_cnt - f0), 128'(1));
      for (int k = 0; k < 17; k++) begin
         aclk_p();
         chk("t4_addr", 128'(row_addr), 128'((k + 1) % ROWS));
      end
      arst_in = 1; step(3);
      chk("t4_addr_arst", 128'(row_addr), 128'(0));
      for (int k = 0; k < 3; k++) aclk_p();
      chk("t4_addr_held", 128'(row_addr), 128'(0));
      arst_in = 0; step(3);
      chk("t4_frame_level", 128'(frame_cnt - f0), 128'(2));

      // last pixel shifted and latched on the same input cycle
      do_reset();
      for (int i = 0; i < COLS - 1; i++) pix(0, 0, 0);
      red_in = 1; sclk_in = 1; latch_in = 1; step(1);
      red_in = 0; sclk_in = 0; latch_in = 0; step(3);
      chk("t5_row_red", 128'(row_red), 128'(32'h0000_0001));
      chk("t5_err_short", 128'(err_short), 128'(0));
      for (int i = 0; i < COLS; i++) pix(0, 0, 0);
      latch_p();
      chk("t5_next_row", 128'({err_short, err_over, row_red}), 128'(0));

      // blank latency
      blank_in = 1; step(4);
      chk("t6_lit_off", 128'(row_lit), 128'(0));
      blank_in = 0; step(1);
      chk("t6_lit_n", 128'(row_lit), 128'(0));
      step(1);
      chk("t6_lit_n1", 128'(row_lit), 128'(0));
      step(1);
      chk("t6_lit_n2", 128'(row_lit), 128'(1));

      // reset during shifting discards the partial row
      do_reset();
      v0 = vld_cnt;
      for (int i = 0; i < 10; i++) pix(1, 1, 1);
      latch_in = 1; reset_n = 0; step(1);
      latch_in = 0; step(2);
      chk("t6_rst_outputs", 128'({row_red, row_green, row_blue, row_addr,
                                   row_valid, row_lit, frame_pulse, err_over, err_short}), 128'(0));
      reset_n = 1; step(4);
      chk("t6_rst_no_valid", 128'(vld_cnt - v0), 128'(0));

      // randomised rows of near-correct length
      for (int r = 0; r < 40; r++) begin
         int len;
         if ($urandom_range(0, 4) == 0) do_reset();
         len = $urandom_range(COLS - 2, COLS + 2);
         for (int i = 0; i < len - 1; i++)
            pix(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 0) begin
            red_in = 1'($urandom_range(0, 1)); sclk_in = 1; latch_in = 1; step(1);
            sclk_in = 0; latch_in = 0; step(2);
         end else begin
            pix(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            latch_p();
         end
         if ($urandom_range(0, 2) == 0) aclk_p();
      end

      // chaotic traffic on every input
      for (int c = 0; c < 3000; c++) begin
         reset_n  = ($urandom_range(0, 299) != 0);
         red_in   = 1'($urandom_range(0, 1));
         green_in = 1'($urandom_range(0, 1));
         blue_in  = 1'($urandom_range(0, 1));
         sclk_in  = 1'($urandom_range(0, 1));
         latch_in = ($urandom_range(0, 39) == 0);
         blank_in = ($urandom_range(0, 3) == 0);
         aclk_in  = ($urandom_range(0, 5) == 0);
         arst_in  = ($urandom_range(0, 59) == 0);
         step(1);
      end

      reset_n = 1; sclk_in = 0; latch_in = 0; aclk_in = 0; arst_in = 0; blank_in = 0;
      step(5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/led_panel_receiver.md
LED_PANEL_RECEIVER -- requirements
Module: led_panel_receiver

Interface
REQ-001 SHALL have parameter COLS, default 32: shift-chain length (pixels per row).
REQ-002 SHALL have parameter ROWS, default 16: row counter modulus; ROWS <= 16.
REQ-003 SHALL have port clk, input, 1: single system clock, the only clock.
REQ-004 SHALL have port reset_n, input, 1: reset, synchronous to clk, active-low.
REQ-005 SHALL have ports red_in, green_in, blue_in, input, 1 each: serial pixel data from the panel driver.
REQ-006 SHALL have ports sclk_in, latch_in, blank_in, aclk_in, arst_in, input, 1 each: panel shift clock, latch, blank, row clock, row reset.
REQ-007 SHALL have ports row_red, row_green, row_blue, output, COLS each: latched row contents.
REQ-008 SHALL have port row_addr, output, 4: current panel row.
REQ-009 SHALL have port row_valid, output, 1: one-cycle pulse when new row data latches.
REQ-010 SHALL have port row_lit, output, 1: row currently displayed (not blanked).
REQ-011 SHALL have port frame_pulse, output, 1: one-cycle pulse on arst_in rising edge.
REQ-012 SHALL have ports err_over, err_short, output, 1 each: sticky protocol error flags.

Function
REQ-013 SHALL pass all eight panel inputs through a two-flop synchroniser; all logic uses synchronised copies only.
REQ-014 SHALL detect rising edges of synchronised sclk, latch, aclk, arst by comparison with a one-cycle-delayed copy.
REQ-015 SHALL make the effect of an input rising edge first sampled at clk edge N visible on outputs after edge N+2.
REQ-016 On sclk rise, SHALL shift each colour register left, new bit into bit 0 (first pixel ends in bit COLS-1 after COLS shifts).
REQ-017 On sclk rise, SHALL increment a shift counter saturating at COLS; an sclk rise with counter already COLS SHALL set err_over.
REQ-018 On latch rise, SHALL copy shift registers to row_red/row_green/row_blue, pulse row_valid for exactly one cycle, clear the shift counter.
REQ-019 On latch rise with shift counter != COLS, SHALL set err_short (counter value evaluated after any same-cycle sclk increment).
REQ-020 On simultaneous sclk and latch rise, SHALL shift first; latched row SHALL include the newly shifted bit; counter ends at 0.
REQ-021 Latch with zero preceding shifts SHALL still latch (current shift contents), pulse row_valid, set err_short.
REQ-022 Shift registers SHALL NOT be cleared by latch; they hold contents until shifted.
REQ-023 While synchronised arst is high (level), row_addr SHALL be held at 0; arst dominates a simultaneous aclk rise.
REQ-024 On aclk rise with arst low, row_addr SHALL increment; at ROWS-1 it SHALL wrap to 0.
REQ-025 frame_pulse SHALL be a one-cycle pulse on each arst rising edge; a level-high arst SHALL NOT re-pulse.
REQ-026 row_lit SHALL equal inverse of synchronised blank_in, registered (same N+2 latency).
REQ-027 err_over and err_short SHALL remain set until reset; no other clear mechanism.

Reset
REQ-028 While reset_n is low at a clk edge, all synchroniser, edge-history, shift, counter and output registers SHALL clear to 0; row_lit SHALL be 0.
REQ-029 Edge-history registers clear to 0, so an input held high through reset deassertion SHALL produce one rising-edge event two cycles later.
REQ-030 Reset asserted mid-row SHALL discard partial shift data; no row_valid pulse during or due to reset.

Verification
REQ-031 32 sclk pulses shifting red=1 on pixel 0 only, then latch -> one row_valid pulse, row_red=0x80000000, err_short=0, err_over=0.
REQ-032 Latch after 31 sclk pulses -> row_valid pulses, err_short=1 and stays 1 after 3 further correct rows; reset_n low -> err_short=0.
REQ-033 33 sclk pulses before latch -> err_over=1; latched row equals last 32 bits shifted.
REQ-034 arst pulse then 17 aclk pulses (ROWS=16) -> row_addr 0,1..15,0,1; frame_pulse exactly once; aclk during arst high -> row_addr stays 0.
REQ-035 sclk and latch rise on same input cycle as 32nd bit -> row contains that bit, err_short=0, counter 0 next row.
REQ-036 blank_in toggled 1->0 at edge N -> row_lit=1 after edge N+2, not before; reset during shifting -> all outputs 0, no row_valid.
